cpu_sequencer: RTL

- Control sequencer that drives the program counter, instruction register, accumulator and memory strobes of the 8-bit RISC CPU.
- Consumes the 3-bit opcode from the instruction register and the accumulator zero flag.
- Emits per-phase enables: PC increment/load, memory read/write, IR/ACC load, address select, data-bus drive and halt.
- Runs an 8-phase instruction cycle; halting is sticky until reset.

---
 rtl/cpu_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: 8-phase control sequencer for the 8-bit RISC CPU.
// Walks INST_ADDR..STORE one phase per clock and decodes per-phase strobes
// from the current phase, the IR opcode and the accumulator zero flag.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   opcode   - IR[7:5]
//   zero     - accumulator == 0
//   addr_sel - 1: address from PC, 0: from IR[4:0]
//   mem_rd, mem_wr, ir_ld, acc_ld, pc_inc, pc_ld, data_oe - phase strobes
//   halt     - CPU halted
//   phase    - current phase (debug)
module cpu_sequencer #(
  parameter bit STICKY_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       addr_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_ld,
  output logic       acc_ld,
  output logic       pc_inc,
  output logic       pc_ld,
  output logic       data_oe,
  output logic       halt,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    PhInstAddr  = 3'd0,
    PhInstFetch = 3'd1,
    PhInstLoad  = 3'd2,
    PhIdle      = 3'd3,
    PhOpAddr    = 3'd4,
    PhOpFetch   = 3'd5,
    PhAluOp     = 3'd6,
    PhStore     = 3'd7
  } phase_e;

  localparam logic [2:0] OpHlt = 3'd0;
  localparam logic [2:0] OpSkz = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpAnd = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpLda = 3'd5;
  localparam logic [2:0] OpSto = 3'd6;
  localparam logic [2:0] OpJmp = 3'd7;

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   alu_op;

  assign alu_op = (opcode == OpAdd) || (opcode == OpAnd) ||
                  (opcode == OpXor) || (opcode == OpLda);

  always_comb begin
    phase_d  = phase_e'(phase_q + 3'd1);
    halted_d = halted_q;
    if (halted_q) begin
      phase_d = phase_q;
    end else if (STICKY_HALT && (phase_q == PhOpAddr) && (opcode == OpHlt)) begin
      // Park in OP_ADDR so the halted state decodes cleanly until reset.
      phase_d  = phase_q;
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= PhInstAddr;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    addr_sel = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    ir_ld    = 1'b0;
    acc_ld   = 1'b0;
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    data_oe  = 1'b0;
    halt     = 1'b0;
    if (halted_q) begin
      // Opcode is ignored once parked; only halt is asserted.
      halt = 1'b1;
    end else begin
      case (phase_q)
        PhInstAddr: begin
          addr_sel = 1'b1;
        end
        PhInstFetch: begin
          addr_sel = 1'b1;
          mem_rd   = 1'b1;
        end
        PhInstLoad, PhIdle: begin
          addr_sel = 1'b1;
          mem_rd   = 1'b1;
          ir_ld    = 1'b1;
        end
        PhOpAddr: begin
          halt   = (opcode == OpHlt);
          pc_inc = (opcode != OpHlt);
        end
        PhOpFetch: begin
          mem_rd = alu_op;
        end
        PhAluOp: begin
          mem_rd  = alu_op;
          pc_inc  = (opcode == OpSkz) && zero;
          pc_ld   = (opcode == OpJmp);
          data_oe = (opcode == OpSto);
        end
        PhStore: begin
          mem_rd  = alu_op;
          acc_ld  = alu_op;
          pc_ld   = (opcode == OpJmp);
          data_oe = (opcode == OpSto);
          mem_wr  = (opcode == OpSto);
        end
        default: ;
      endcase
    end
  end

  assign phase = phase_q;

endmodule
